hiscore_engine: RTL and testbench
=================================

Name: hiscore_engine

Overview:
- Initiator on the game-RAM hiscore port (HSAD/HSDI/HSWE out, HSDO in) exposed by the System 1 top.
- After boot it waits for the game to initialise its score table, then restores a host-supplied table into game RAM. On request it dumps the table from game RAM back to the host buffer.
- Sits beside the core in the MiSTer wrapper, between the game-RAM port and the host (ioctl) side.

Parameters:
- BASE, 12'h000, game-RAM address of the first table byte.
- LEN, 64, table length in bytes (1..256).
- SIG0, 8'h00, expected default value of table byte 0 once the game has initialised it.
- SIG1, 8'h00, expected default value of table byte LEN-1.
- WAIT_FR, 8'd60, VBLK rising edges to wait after reset before the first check.

Ports:
- clk48M  in  1  system clock
- reset  in  1  synchronous, active-high
- VBLK  in  1  vertical blank from the core
- HSAD  out  12  game-RAM address
- HSDO  in  8  game-RAM read data; valid 1 cycle after HSAD
- HSDI  out  8  game-RAM write data
- HSWE  out  8  write enable; all 8 bits driven identically
- ho_ad  in  8  host buffer address
- ho_di  in  8  host buffer write data
- ho_we  in  1  host buffer write strobe
- ho_do  out  8  host buffer read data; 1-cycle latency
- ho_loaded  in  1  level: host has filled the buffer
- sv_req  in  1  pulse: dump game RAM to buffer
- busy  out  1  high during CHECK, RESTORE or SAVE
- sv_done  out  1  1-cycle pulse when a dump completes
- restored  out  1  sticky, set when a restore completes

Behaviour:
- Reset values: HSAD=BASE, HSDI=0, HSWE=0, ho_do=0, busy=0, sv_done=0, restored=0, state=WAIT, frame counter=0, byte index=0.
- Buffer: internal dual-port 256x8.
  - Host port: write on ho_we; read registered.
  - Engine port: its own address, 1-cycle read.
  - Simultaneous host and engine writes to the same address: engine wins.
- Access window: the engine issues game-RAM cycles only while VBLK=1. When VBLK falls mid-operation, the engine freezes: HSWE=0, index held. It resumes at the same index on the next VBLK=1, and the pending read is re-issued.
- Read cycle: drive HSAD at cycle N, sample HSDO at N+1.
- Write cycle: HSAD/HSDI/HSWE asserted for exactly 1 cycle per byte. HSWE returns to 0 on the following cycle.
- WAIT state:
  - Count VBLK rising edges; the counter saturates at WAIT_FR.
  - Leave WAIT when count==WAIT_FR and ho_loaded=1 → CHECK.
  - If ho_loaded=0 when the count completes → ARMED (nothing to restore).
- CHECK state:
  - Read BASE, then BASE+LEN-1.
  - Both equal SIG0/SIG1 → RESTORE.
  - Otherwise → WAIT, with the counter reset to 0; the check is retried after another WAIT_FR frames.
- RESTORE state:
  - For i=0..LEN-1: read buffer[i], then write game RAM at BASE+i.
  - Rate: 1 byte per 2 active cycles.
  - After i=LEN-1: restored←1, → ARMED.
- ARMED state: idle. sv_req → SAVE. sv_req in any other state is ignored (not queued).
- SAVE state:
  - For i=0..LEN-1: read game RAM at BASE+i, then write buffer[i].
  - After the last byte: sv_done pulses 1 cycle, → ARMED.
- busy=1 exactly in CHECK, RESTORE and SAVE.
- Index arithmetic: 8-bit index. Address = BASE+i, truncated to 12 bits, so it wraps past 12'hFFF.
- reset mid-operation: immediate return to WAIT with all outputs at reset values. The buffer contents are retained. restored is cleared.

Test Plan:
- Boot path: reset, ho_loaded=1, game RAM preset with SIG0/SIG1, WAIT_FR=2, 2 VBLK edges → CHECK reads BASE and BASE+63, then 64 HSWE pulses (all 8 bits high) at HSAD=BASE..BASE+63 with HSDI=buffer[i]; restored=1.
- Signature mismatch: byte 0 ≠ SIG0 → no HSWE pulses, return to WAIT; after the signature is corrected, restore occurs 2 frames later.
- No host data: ho_loaded=0 → ARMED with zero RAM writes; restored stays 0.
- Save: in ARMED, fill RAM BASE..BASE+63 with i^8'h5A and pulse sv_req → sv_done pulses once; ho_do at ho_ad=i reads i^8'h5A for all i.
- VBLK gating: drop VBLK midway through RESTORE at i=20 → HSWE=0 while VBLK=0; on resume byte 20 is written once, never duplicated or skipped.
- Reset mid-SAVE at i=10 → HSWE=0, busy=0, state WAIT next cycle; buffer bytes 0..9 hold the newly dumped values and bytes 10..63 are unchanged.

Source files
------------

// File: rtl/hiscore_engine_if.sv
// Game-RAM hiscore port: the engine drives address/data/write enable and receives
// read data one cycle after the address.
interface hiscore_engine_if;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    logic [AW-1:0] HSAD;
    logic [DW-1:0] HSDI;
    logic [DW-1:0] HSWE;
    logic [DW-1:0] HSDO;

    modport master (output HSAD, output HSDI, output HSWE, input HSDO);
    modport slave  (input HSAD, input HSDI, input HSWE, output HSDO);
endinterface

// File: rtl/hiscore_engine.sv
// Hiscore table engine: restores a host-supplied table into game RAM after boot and
// dumps it back to the host buffer on request. Game-RAM cycles only run during VBLK.
module hiscore_engine #(
    parameter logic [11:0] BASE    = 12'h000,
    parameter int unsigned LEN     = 64,
    parameter logic [7:0]  SIG0    = 8'h00,
    parameter logic [7:0]  SIG1    = 8'h00,
    parameter logic [7:0]  WAIT_FR = 8'd60
) (
    input  logic                clk48M,
    input  logic                reset,
    input  logic                VBLK,
    hiscore_engine_if.master    hs,
    input  logic [7:0]          ho_ad,
    input  logic [7:0]          ho_di,
    input  logic                ho_we,
    output logic [7:0]          ho_do,
    input  logic                ho_loaded,
    input  logic                sv_req,
    output logic                busy,
    output logic                sv_done,
    output logic                restored
);
    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 8;
    localparam int unsigned IW    = 8;
    localparam int unsigned DEPTH = 256;

    typedef enum logic [2:0] {
        S_WAIT,
        S_CHECK,
        S_RESTORE,
        S_ARMED,
        S_SAVE
    } state_t;

    state_t        r_state, w_state;
    logic [IW-1:0] r_cnt, w_cnt;
    logic [IW-1:0] r_idx, w_idx;
    logic [1:0]    r_ph, w_ph;
    logic          r_sig_ok, w_sig_ok;
    logic [AW-1:0] r_hsad, w_hsad;
    logic [DW-1:0] r_hsdi, w_hsdi;
    logic          r_hswe, w_hswe;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
    logic          r_restored, w_restored;
    logic          w_eng_we;

    logic [DW-1:0] r_buf [DEPTH];
    logic [DW-1:0] r_eng_rd;
    logic [DW-1:0] r_ho_do;
    logic          r_vblk_d;

    logic          w_vblk_rise;
    logic          w_last;
    logic [AW-1:0] w_addr_i;
    logic [AW-1:0] w_addr_last;

    assign w_vblk_rise = VBLK & ~r_vblk_d;
    assign w_last      = (r_idx == IW'(LEN - 1));
    assign w_addr_i    = AW'(BASE + AW'(r_idx));
    assign w_addr_last = AW'(BASE + AW'(LEN - 1));

    assign hs.HSAD  = r_hsad;
    assign hs.HSDI  = r_hsdi;
    assign hs.HSWE  = {DW{r_hswe}};
    assign ho_do    = r_ho_do;
    assign busy     = r_busy;
    assign sv_done  = r_done;
    assign restored = r_restored;

    // Buffer: host write first so a same-address engine write overrides it
    always_ff @(posedge clk48M) begin
        if (ho_we) begin
            r_buf[ho_ad] <= ho_di;
        end
        if (w_eng_we && !reset) begin
            r_buf[r_idx] <= hs.HSDO;
        end
        r_eng_rd <= r_buf[r_idx];
    end

    always_ff @(posedge clk48M) begin
        if (reset) begin
            r_ho_do <= '0;
        end else begin
            r_ho_do <= r_buf[ho_ad];
        end
    end

    always_ff @(posedge clk48M) begin
        r_vblk_d <= VBLK;
    end

    // State register
    always_ff @(posedge clk48M) begin
        if (reset) begin
            r_state    <= S_WAIT;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_ph       <= '0;
            r_sig_ok   <= 1'b0;
            r_hsad     <= BASE;
            r_hsdi     <= '0;
            r_hswe     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_restored <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_idx      <= w_idx;
            r_ph       <= w_ph;
            r_sig_ok   <= w_sig_ok;
            r_hsad     <= w_hsad;
            r_hsdi     <= w_hsdi;
            r_hswe     <= w_hswe;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_restored <= w_restored;
        end
    end

    // Next state; a VBLK drop rewinds the phase so the current byte's read is re-issued
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_idx      = r_idx;
        w_ph       = r_ph;
        w_sig_ok   = r_sig_ok;
        w_hsad     = r_hsad;
        w_hsdi     = r_hsdi;
        w_hswe     = 1'b0;
        w_done     = 1'b0;
        w_restored = r_restored;
        w_eng_we   = 1'b0;

        case (r_state)
            S_WAIT: begin
                if (w_vblk_rise && (r_cnt != WAIT_FR)) begin
                    w_cnt = r_cnt + IW'(1);
                end
                if (r_cnt == WAIT_FR) begin
                    w_idx   = '0;
                    w_ph    = '0;
                    w_state = ho_loaded ? S_CHECK : S_ARMED;
                end
            end

            S_CHECK: begin
                if (!VBLK) begin
                    w_ph = '0;
                end else if (r_ph == 2'd0) begin
                    w_hsad = (r_idx == '0) ? BASE : w_addr_last;
                    w_ph   = 2'd1;
                end else if (r_ph == 2'd1) begin
                    w_ph = 2'd2;
                end else if (r_idx == '0) begin
                    w_sig_ok = (hs.HSDO == SIG0);
                    w_idx    = IW'(1);
                    w_ph     = '0;
                end else begin
                    w_idx = '0;
                    w_ph  = '0;
                    if (r_sig_ok && (hs.HSDO == SIG1)) begin
                        w_state = S_RESTORE;
                    end else begin
                        w_state = S_WAIT;
                        w_cnt   = '0;
                    end
                end
            end

            // Phase 0 lets the buffer read of r_idx land; phase 1 issues the write
            S_RESTORE: begin
                if (!VBLK) begin
                    w_ph = '0;
                end else if (r_ph == 2'd0) begin
                    w_ph = 2'd1;
                end else begin
                    w_hsad = w_addr_i;
                    w_hsdi = r_eng_rd;
                    w_hswe = 1'b1;
                    w_ph   = '0;
                    if (w_last) begin
                        w_idx      = '0;
                        w_restored = 1'b1;
                        w_state    = S_ARMED;
                    end else begin
                        w_idx = r_idx + IW'(1);
                    end
                end
            end

            S_ARMED: begin
                if (sv_req) begin
                    w_idx   = '0;
                    w_ph    = '0;
                    w_state = S_SAVE;
                end
            end

            S_SAVE: begin
                if (!VBLK) begin
                    w_ph = '0;
                end else if (r_ph == 2'd0) begin
                    w_hsad = w_addr_i;
                    w_ph   = 2'd1;
                end else if (r_ph == 2'd1) begin
                    w_ph = 2'd2;
                end else begin
                    w_eng_we = 1'b1;
                    w_ph     = '0;
                    if (w_last) begin
                        w_idx   = '0;
                        w_done  = 1'b1;
                        w_state = S_ARMED;
                    end else begin
                        w_idx = r_idx + IW'(1);
                    end
                end
            end

            default: begin
                w_state = S_WAIT;
            end
        endcase

        w_busy = (w_state == S_CHECK) || (w_state == S_RESTORE) || (w_state == S_SAVE);
    end
endmodule

// File: tb/tb_hiscore_engine.sv
// Directed bench for hiscore_engine: game-RAM model, write/done/read scoreboards
// checked by a negedge monitor, and directed boot/mismatch/no-data/save/reset scenarios.
module tb_hiscore_engine;
    localparam logic [11:0] BASE    = 12'hFE0;
    localparam int          LEN     = 64;
    localparam logic [7:0]  SIG0    = 8'hA5;
    localparam logic [7:0]  SIG1    = 8'h3C;
    localparam logic [7:0]  WAIT_FR = 8'd2;

    logic       clk48M = 1'b0;
    logic       reset;
    logic       VBLK;
    logic [7:0] ho_ad, ho_di, ho_do;
    logic       ho_we, ho_loaded, sv_req, busy, sv_done, restored;

    logic        pre_we;
    logic [11:0] pre_a;
    logic [7:0]  pre_d;
    logic        rd_vld, rd_vld_d;

    logic [7:0]  gram [4096];
    logic [19:0] wq [$];
    logic [7:0]  rq [$];
    int          dq [$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_wr   = 0;
    int n_done = 0;

    hiscore_engine_if hs ();

    hiscore_engine #(
        .BASE(BASE), .LEN(LEN), .SIG0(SIG0), .SIG1(SIG1), .WAIT_FR(WAIT_FR)
    ) dut (
        .clk48M(clk48M), .reset(reset), .VBLK(VBLK), .hs(hs),
        .ho_ad(ho_ad), .ho_di(ho_di), .ho_we(ho_we), .ho_do(ho_do),
        .ho_loaded(ho_loaded), .sv_req(sv_req), .busy(busy),
        .sv_done(sv_done), .restored(restored)
    );

    always #5 clk48M = ~clk48M;

    // Game RAM: registered read, write on HSWE, plus a bench preset port
    always @(posedge clk48M) begin
        hs.HSDO <= gram[hs.HSAD];
        if (hs.HSWE[0]) gram[hs.HSAD] <= hs.HSDI;
        if (pre_we) gram[pre_a] <= pre_d;
        rd_vld_d <= rd_vld;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] hval(input int i);
        return 8'(i * 3 + 7);
    endfunction

    // Monitor: pops the scoreboards whenever the DUT shows a write, a done pulse or read data
    always @(negedge clk48M) begin
        logic [19:0] e;
        logic [7:0]  r;
        if (hs.HSWE != 8'h00) begin
            n_wr++;
            chk("hswe_all_bits", 32'(hs.HSWE), 32'hFF);
            chk("wr_expected", 32'(wq.size() > 0), 32'd1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                chk("wr_addr", 32'(hs.HSAD), 32'(e[19:8]));
                chk("wr_data", 32'(hs.HSDI), 32'(e[7:0]));
            end
        end
        if (sv_done) begin
            n_done++;
            chk("done_expected", 32'(dq.size() > 0), 32'd1);
            if (dq.size() > 0) void'(dq.pop_front());
        end
        if (rd_vld_d) begin
            chk("rd_expected", 32'(rq.size() > 0), 32'd1);
            if (rq.size() > 0) begin
                r = rq.pop_front();
                chk("ho_do", 32'(ho_do), 32'(r));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk48M);
        #1;
    endtask

    task automatic frame(input int hi);
        VBLK = 1'b1; tick(hi);
        VBLK = 1'b0; tick(10);
    endtask

    task automatic gset(input logic [11:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_a = a; pre_d = d; tick(1);
        pre_we = 1'b0;
    endtask

    task automatic hread(input logic [7:0] a, input logic [7:0] exp);
        ho_ad = a; rq.push_back(exp); rd_vld = 1'b1; tick(1);
        rd_vld = 1'b0;
    endtask

    task automatic push_restore();
        for (int i = 0; i < LEN; i++) wq.push_back({12'(BASE + 12'(i)), hval(i)});
    endtask

    task automatic pulse_req();
        sv_req = 1'b1; tick(1);
        sv_req = 1'b0;
    endtask

    initial begin
        int  base;
        int  prev;
        bit  found;
        reset = 1'b1; VBLK = 1'b0; ho_ad = '0; ho_di = '0; ho_we = 1'b0;
        ho_loaded = 1'b0; sv_req = 1'b0; rd_vld = 1'b0; rd_vld_d = 1'b0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;
        tick(3);

        // Reset values
        chk("rst_hsad", 32'(hs.HSAD), 32'(BASE));
        chk("rst_hsdi", 32'(hs.HSDI), 32'h0);
        chk("rst_hswe", 32'(hs.HSWE), 32'h0);
        chk("rst_ho_do", 32'(ho_do), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sv_done", 32'(sv_done), 32'h0);
        chk("rst_restored", 32'(restored), 32'h0);

        // Boot path with address wrap past 12'hFFF
        gset(BASE, SIG0);
        gset(12'(BASE + 12'd63), SIG1);
        reset = 1'b0; tick(1);
        for (int i = 0; i < LEN; i++) begin
            ho_ad = 8'(i); ho_di = hval(i); ho_we = 1'b1; tick(1);
        end
        ho_we = 1'b0; ho_loaded = 1'b1;
        push_restore();
        frame(5);
        chk("boot_no_early_write", 32'(n_wr), 32'd0);
        VBLK = 1'b1; tick(30);
        chk("boot_busy", 32'(busy), 32'd1);
        tick(270); VBLK = 1'b0; tick(5);
        chk("boot_writes", 32'(n_wr), 32'd64);
        chk("boot_restored", 32'(restored), 32'd1);
        chk("boot_idle", 32'(busy), 32'd0);
        chk("boot_queue_empty", 32'(wq.size()), 32'd0);

        // VBLK gating mid-restore at byte 20
        reset = 1'b1; tick(2);
        chk("rst_clears_restored", 32'(restored), 32'd0);
        gset(BASE, SIG0);
        gset(12'(BASE + 12'd63), SIG1);
        reset = 1'b0; tick(1);
        hread(8'd5, hval(5));
        push_restore();
        base = n_wr;
        frame(5);
        VBLK = 1'b1; found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            tick(1);
            if (hs.HSWE[0] && hs.HSAD == 12'(BASE + 12'd19)) found = 1'b1;
        end
        chk("gate_reached_19", 32'(found), 32'd1);
        tick(1); VBLK = 1'b0;
        tick(20);
        chk("gate_frozen_count", 32'(n_wr - base), 32'd20);
        chk("gate_busy_held", 32'(busy), 32'd1);
        VBLK = 1'b1; tick(200); VBLK = 1'b0; tick(5);
        chk("gate_total", 32'(n_wr - base), 32'd64);
        chk("gate_restored", 32'(restored), 32'd1);

        // Signature mismatch, then corrected
        reset = 1'b1; tick(2);
        gset(BASE, SIG0 ^ 8'h01);
        gset(12'(BASE + 12'd63), SIG1);
        reset = 1'b0; tick(1);
        base = n_wr;
        frame(5); frame(60);
        chk("mis_no_writes", 32'(n_wr - base), 32'd0);
        chk("mis_restored", 32'(restored), 32'd0);
        chk("mis_idle", 32'(busy), 32'd0);
        gset(BASE, SIG0);
        push_restore();
        frame(5);
        chk("mis_retry_waits", 32'(n_wr - base), 32'd0);
        frame(300);
        chk("mis_retry_writes", 32'(n_wr - base), 32'd64);
        chk("mis_retry_restored", 32'(restored), 32'd1);

        // No host data: straight to ARMED
        reset = 1'b1; ho_loaded = 1'b0; tick(2);
        reset = 1'b0; tick(1);
        base = n_wr;
        pulse_req(); tick(2);
        chk("req_ignored_wait", 32'(busy), 32'd0);
        frame(5); frame(20);
        chk("nodata_no_writes", 32'(n_wr - base), 32'd0);
        chk("nodata_restored", 32'(restored), 32'd0);
        chk("nodata_idle", 32'(busy), 32'd0);

        // Save from ARMED
        for (int i = 0; i < LEN; i++) gset(12'(BASE + 12'(i)), 8'(i) ^ 8'h5A);
        VBLK = 1'b1;
        prev = n_done;
        dq.push_back(1);
        pulse_req(); tick(1);
        chk("save_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 600 && n_done == prev; k++) tick(1);
        chk("save_done_once", 32'(n_done - prev), 32'd1);
        tick(3);
        chk("save_idle", 32'(busy), 32'd0);
        chk("save_no_ram_writes", 32'(n_wr - base), 32'd0);
        for (int i = 0; i < LEN; i++) hread(8'(i), 8'(i) ^ 8'h5A);

        // Reset during save at byte 10
        for (int i = 0; i < LEN; i++) gset(12'(BASE + 12'(i)), 8'(i + 8'h80));
        pulse_req();
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (hs.HSAD == 12'(BASE + 12'd10)) found = 1'b1;
            else tick(1);
        end
        chk("save_reached_10", 32'(found), 32'd1);
        reset = 1'b1; tick(1);
        chk("rs_hswe", 32'(hs.HSWE), 32'h0);
        chk("rs_busy", 32'(busy), 32'h0);
        chk("rs_hsad", 32'(hs.HSAD), 32'(BASE));
        chk("rs_sv_done", 32'(sv_done), 32'h0);
        reset = 1'b0; VBLK = 1'b0; tick(3);
        chk("rs_stays_wait", 32'(busy), 32'h0);
        for (int i = 0; i < LEN; i++)
            hread(8'(i), (i < 10) ? 8'(i + 8'h80) : (8'(i) ^ 8'h5A));
        tick(3);

        chk("final_wq_empty", 32'(wq.size()), 32'd0);
        chk("final_dq_empty", 32'(dq.size()), 32'd0);
        chk("final_rq_empty", 32'(rq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
